// File: rtl/demod_lpf_pkg.sv
// demod_lpf_pkg: shared FSM encoding and select-width constants for the lowpass
// sequencer and the biquad engine it drives.
package demod_lpf_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;
   localparam int NUM_CH_DEF = 4;
   localparam int NUM_STAGES_DEF = 2;
   localparam int ENG_LAT_DEF = 3;
   localparam int CNT_W = 4;
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int CH_W = sel_w(NUM_CH_DEF);
   localparam int STG_W = sel_w(NUM_STAGES_DEF);
endpackage

// File: rtl/demod_lpf_rr_arb.sv
// demod_lpf_rr_arb: combinational round-robin pick of the first pending channel
// strictly after rr_ptr, wrapping.
module demod_lpf_rr_arb #(
   parameter int NUM_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [NUM_CH-1:0] pending,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [CH_W-1:0]   grant,
   output logic              any
);
   logic [CH_W:0] idx;
   // Scan farthest to nearest so the nearest pending channel overwrites the rest.
   always_comb begin
      grant = '0;
      any = 1'b0;
      idx = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
         idx = (idx >= (CH_W+1)'(NUM_CH)) ? idx - (CH_W+1)'(NUM_CH) : idx;
         if (pending[idx[CH_W-1:0]]) begin
            grant = idx[CH_W-1:0];
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/demod_lpf_sched.sv
// demod_lpf_sched: time-shares one biquad engine between NUM_CH channels, stepping
// NUM_STAGES sections per sample. DEMOD_LPF_SCHED_OVR_CNT_EN adds ovr_count/ovr_clr.
module demod_lpf_sched
   import demod_lpf_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int ENG_LAT = ENG_LAT_DEF,
   localparam int CW = sel_w(NUM_CH),
   localparam int SW = sel_w(NUM_STAGES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_strobe,
   output logic              eng_start,
   output logic              eng_load,
   output logic [CW-1:0]     eng_ch_sel,
   output logic [SW-1:0]     eng_stage_sel,
   output logic              eng_state_we,
   output logic              out_valid,
   output logic [CW-1:0]     out_ch,
   input  logic              out_ready,
   output logic              overrun,
`ifdef DEMOD_LPF_SCHED_OVR_CNT_EN
   input  logic              ovr_clr,
   output logic [15:0]       ovr_count,
`endif
   output logic              busy
);
   state_e state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ch_q, ch_d, rr_q, rr_d, out_ch_q, out_ch_d, grant;
   logic [NUM_CH-1:0] pending_q, pending_d, gnt_vec;
   logic any;
   logic start_q, start_d, load_q, load_d, we_q, we_d;
   logic valid_q, valid_d, ovr_q, ovr_d, busy_q, busy_d;

   demod_lpf_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CW)) u_arb (
      .pending(pending_q),
      .rr_ptr(rr_q),
      .grant(grant),
      .any(any)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         stage_q <= '0;
         cnt_q <= '0;
         ch_q <= '0;
         rr_q <= CW'(NUM_CH-1);
         pending_q <= '0;
         out_ch_q <= '0;
         start_q <= 1'b0;
         load_q <= 1'b0;
         we_q <= 1'b0;
         valid_q <= 1'b0;
         ovr_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q <= cnt_d;
         ch_q <= ch_d;
         rr_q <= rr_d;
         pending_q <= pending_d;
         out_ch_q <= out_ch_d;
         start_q <= start_d;
         load_q <= load_d;
         we_q <= we_d;
         valid_q <= valid_d;
         ovr_q <= ovr_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d = cnt_q;
      ch_d = ch_q;
      rr_d = rr_q;
      gnt_vec = '0;
      case (state_q)
         IDLE: if (any) begin
            ch_d = grant;
            rr_d = grant;
            stage_d = '0;
            gnt_vec[grant] = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d = CNT_W'(ENG_LAT-1);
            state_d = WAIT;
         end
         WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else if (stage_q == SW'(NUM_STAGES-1)) state_d = OUT;
         else begin
            stage_d = stage_q + 1'b1;
            state_d = ISSUE;
         end
         OUT: state_d = out_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
      // A strobe arriving with its own grant re-arms the channel rather than being lost.
      pending_d = (pending_q & ~gnt_vec) | ch_strobe;
   end

   // Outputs decode the next state so every output is a plain flop.
   always_comb begin
      start_d = state_d == ISSUE;
      load_d = state_d == ISSUE && stage_d == '0;
      we_d = state_d == WAIT && cnt_d == '0;
      valid_d = state_d == OUT;
      out_ch_d = (state_d == OUT) ? ch_d : '0;
      busy_d = state_d != IDLE;
      ovr_d = |(ch_strobe & pending_q & ~gnt_vec);
   end

   assign eng_start = start_q;
   assign eng_load = load_q;
   assign eng_ch_sel = ch_q;
   assign eng_stage_sel = stage_q;
   assign eng_state_we = we_q;
   assign out_valid = valid_q;
   assign out_ch = out_ch_q;
   assign overrun = ovr_q;
   assign busy = busy_q;

`ifdef DEMOD_LPF_SCHED_OVR_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;
   always_comb begin
      ovr_cnt_d = ovr_clr ? 16'h0 :
                  (ovr_q && ovr_cnt_q != 16'hFFFF) ? ovr_cnt_q + 16'h1 : ovr_cnt_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ovr_cnt_q <= '0;
      else ovr_cnt_q <= ovr_cnt_d;
   end
   assign ovr_count = ovr_cnt_q;
`endif
endmodule
